load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: FSM states, access size codes
// and small helpers that turn a size code into byte counts.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Halfword wins over byte when both select lines are set.
    function automatic lsu_size_t decode_size(input logic is_half, input logic is_byte);
        if (is_half) begin
            return SZ_HALF;
        end else if (is_byte) begin
            return SZ_BYTE;
        end
        return SZ_WORD;
    endfunction

    // Index of the final byte of a transfer (N-1).
    function automatic logic [1:0] last_cnt(input lsu_size_t size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit. One request is latched in IDLE, then the
// access is moved one byte per cycle (big-endian) over an 8-bit memory port,
// followed by a single DONE cycle. Loads are assembled in a shift
// accumulator and sign/zero extended when DONE is entered.
//
// Handshake: a request is taken on a rising edge where ready=1 and req=1.
// ready is low for the whole access; req is ignored then and nothing queues.
// done pulses for exactly one cycle when the access has completed.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [31:0] SEG    = 32'h0,
    parameter int          MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       wd,
    input  logic              Memhalf,
    input  logic              Membyte,
    input  logic              MemExt,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd
);

    lsu_state_t        state, state_next;
    lsu_size_t         size_in, size_q;
    logic [31:0]       seg_addr, aligned;
    logic [MEM_AW-1:0] base_q;
    logic              we_q, ext_q;
    logic [31:0]       wd_q;
    logic [1:0]        cnt, last, byte_idx;
    logic [31:0]       acc, acc_next, load_val;
    logic              accept, xfer_end;
    logic              unused_bits;

    assign size_in  = decode_size(Memhalf, Membyte);
    assign seg_addr = addr + SEG;
    assign last     = last_cnt(size_q);
    assign byte_idx = last - cnt;
    assign accept   = (state == IDLE) && req;
    assign xfer_end = (state == XFER) && (cnt == last);
    assign acc_next = {acc[23:0], mem_rd};

    // Address bits above the memory width and the byte shifted out of the
    // accumulator carry no information for this memory.
    assign unused_bits = ^{aligned[31:MEM_AW], acc[31:24]};

    // Misaligned half/word requests are silently forced onto their boundary.
    always_comb begin
        aligned = seg_addr;
        case (size_in)
            SZ_HALF: aligned[0]   = 1'b0;
            SZ_WORD: aligned[1:0] = 2'b00;
            default: ;
        endcase
    end

    // Final load value: keep 8*N accumulator bits and extend from the top byte.
    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = {{24{ext_q & acc_next[7]}},  acc_next[7:0]};
            SZ_HALF: load_val = {{16{ext_q & acc_next[15]}}, acc_next[15:0]};
            default: load_val = acc_next;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-port outputs; the port is quiet outside XFER.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = 8'h00;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                mem_addr = base_q + MEM_AW'(cnt);
                mem_we   = we_q;
                mem_wd   = we_q ? wd_q[{byte_idx, 3'b000} +: 8] : 8'h00;
                if (cnt == last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, byte counter, load accumulator and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            we_q   <= 1'b0;
            wd_q   <= 32'h0;
            size_q <= SZ_BYTE;
            ext_q  <= 1'b0;
            cnt    <= 2'd0;
            acc    <= 32'h0;
            rdata  <= 32'h0;
        end else begin
            if (accept) begin
                base_q <= aligned[MEM_AW-1:0];
                we_q   <= we;
                wd_q   <= wd;
                size_q <= size_in;
                ext_q  <= MemExt;
                cnt    <= 2'd0;
            end
            if (state == XFER) begin
                cnt <= xfer_end ? 2'd0 : cnt + 2'd1;
                if (!we_q) begin
                    acc <= acc_next;
                end
                if (xfer_end && !we_q) begin
                    rdata <= load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with SEG=0 and one with
// SEG=0xFFC, each attached to its own 4096-byte behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] addr = 32'h0, wd = 32'h0;
    logic        we = 1'b0, Memhalf = 1'b0, Membyte = 1'b0, MemExt = 1'b0;

    logic        ready0, done0, mem_we0;
    logic [31:0] rdata0;
    logic [11:0] mem_addr0;
    logic [7:0]  mem_wd0, mem_rd0;
    logic        ready1, done1, mem_we1;
    logic [31:0] rdata1;
    logic [11:0] mem_addr1;
    logic [7:0]  mem_wd1, mem_rd1;

    logic [7:0] mem0 [0:4095];
    logic [7:0] mem1 [0:4095];

    int tests = 0;
    int fails = 0;

    // clock / reset block
    always #5 clk = ~clk;

    load_store_unit #(.SEG(32'h0), .MEM_AW(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req0), .ready(ready0), .addr(addr),
        .we(we), .wd(wd), .Memhalf(Memhalf), .Membyte(Membyte), .MemExt(MemExt),
        .done(done0), .rdata(rdata0), .mem_addr(mem_addr0), .mem_we(mem_we0),
        .mem_wd(mem_wd0), .mem_rd(mem_rd0)
    );

    load_store_unit #(.SEG(32'hFFC), .MEM_AW(12)) u_seg (
        .clk(clk), .rst_n(rst_n), .req(req1), .ready(ready1), .addr(addr),
        .we(we), .wd(wd), .Memhalf(Memhalf), .Membyte(Membyte), .MemExt(MemExt),
        .done(done1), .rdata(rdata1), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    // behavioural byte memories: combinational read, posedge write
    assign mem_rd0 = mem0[mem_addr0];
    assign mem_rd1 = mem1[mem_addr1];
    always @(posedge clk) if (mem_we0) mem0[mem_addr0] <= mem_wd0;
    always @(posedge clk) if (mem_we1) mem1[mem_addr1] <= mem_wd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: issue one request on the selected instance, return the cycle
    // (counted from the accepting edge) in which done was seen, and rdata then
    task automatic do_access(input bit sel, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic h, input logic b,
                             input logic e, output int dcyc, output logic [31:0] rd);
        @(negedge clk);
        check("ready_before_req", {31'h0, sel ? ready1 : ready0}, 32'h1);
        check("done_low_idle",    {31'h0, sel ? done1 : done0},   32'h0);
        addr = a; we = w; wd = d; Memhalf = h; Membyte = b; MemExt = e;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        dcyc = -1;
        rd   = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel ? done1 : done0) begin
                dcyc = k;
                rd   = sel ? rdata1 : rdata0;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc;
        logic [31:0] rd;
        int          low_cnt, done_cnt;
        logic [31:0] first_rd;

        // reset state
        #1;
        check("rst_ready",    {31'h0, ready0},  32'h1);
        check("rst_done",     {31'h0, done0},   32'h0);
        check("rst_mem_we",   {31'h0, mem_we0}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr0}, 32'h0);
        check("rst_mem_wd",   {24'h0, mem_wd0}, 32'h0);
        check("rst_rdata",    rdata0,           32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // word store, big-endian bytes, done in cycle 5
        do_access(0, 1, 32'h10, 32'h11223344, 0, 0, 0, dc, rd);
        check("wst_done_cycle", 32'(dc), 32'd5);
        check("wst_m10", {24'h0, mem0[12'h010]}, 32'h11);
        check("wst_m11", {24'h0, mem0[12'h011]}, 32'h22);
        check("wst_m12", {24'h0, mem0[12'h012]}, 32'h33);
        check("wst_m13", {24'h0, mem0[12'h013]}, 32'h44);
        check("wst_rdata_kept", rdata0, 32'h0);

        // byte stores use only the low byte of wd
        do_access(0, 1, 32'h10, 32'hAABBCC80, 0, 1, 0, dc, rd);
        check("bst_done_cycle", 32'(dc), 32'd2);
        check("bst_m10", {24'h0, mem0[12'h010]}, 32'h80);
        do_access(0, 1, 32'h11, 32'h00000001, 0, 1, 0, dc, rd);
        check("bst_m11", {24'h0, mem0[12'h011]}, 32'h01);

        // misaligned half loads, sign and zero extension
        do_access(0, 0, 32'h11, 32'h0, 1, 0, 1, dc, rd);
        check("hld_done_cycle", 32'(dc), 32'd3);
        check("hld_sext", rd, 32'hFFFF8001);
        do_access(0, 0, 32'h11, 32'h0, 1, 0, 0, dc, rd);
        check("hld_zext", rd, 32'h00008001);

        // byte loads
        do_access(0, 1, 32'h07, 32'h000000F0, 0, 1, 0, dc, rd);
        do_access(0, 0, 32'h07, 32'h0, 0, 1, 1, dc, rd);
        check("bld_done_cycle", 32'(dc), 32'd2);
        check("bld_sext", rd, 32'hFFFFFFF0);
        do_access(0, 0, 32'h07, 32'h0, 0, 1, 0, dc, rd);
        check("bld_zext", rd, 32'h000000F0);

        // misaligned word load, MemExt has no effect
        do_access(0, 0, 32'h13, 32'h0, 0, 0, 1, dc, rd);
        check("wld_done_cycle", 32'(dc), 32'd5);
        check("wld_value", rd, 32'h80013344);

        // halfword has priority over byte
        do_access(0, 0, 32'h10, 32'h0, 1, 1, 0, dc, rd);
        check("prio_done_cycle", 32'(dc), 32'd3);
        check("prio_value", rd, 32'h00008001);

        // misaligned half store, rdata untouched by stores
        do_access(0, 1, 32'h23, 32'h1234BEEF, 1, 0, 0, dc, rd);
        check("hst_m22", {24'h0, mem0[12'h022]}, 32'hBE);
        check("hst_m23", {24'h0, mem0[12'h023]}, 32'hEF);
        check("hst_rdata_kept", rdata0, 32'h00008001);
        do_access(0, 1, 32'h20, 32'h000000DD, 0, 1, 0, dc, rd);
        do_access(0, 1, 32'h21, 32'h00000000, 0, 1, 0, dc, rd);

        // req held high with a wandering address: one access, then the next
        @(negedge clk);
        addr = 32'h10; we = 1'b0; wd = 32'h0; Memhalf = 1'b0; Membyte = 1'b0;
        MemExt = 1'b0; req0 = 1'b1;
        @(posedge clk);
        low_cnt  = 0;
        done_cnt = 0;
        first_rd = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!ready0) low_cnt++;
            if (done0) begin
                done_cnt++;
                first_rd = rdata0;
            end
            addr = (k == 6) ? 32'h20 : $urandom_range(0, 4095);
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        check("hold_ready_low_cycles", 32'(low_cnt), 32'd5);
        check("hold_done_pulses", 32'(done_cnt), 32'd1);
        check("hold_first_value", first_rd, 32'h80013344);
        dc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done0) begin
                dc = k;
                break;
            end
        end
        check("hold_second_cycle", 32'(dc), 32'd5);
        check("hold_second_value", rdata0, 32'hDD00BEEF);

        // reset after two bytes of a word store
        do_access(0, 1, 32'h30, 32'h00000000, 0, 0, 0, dc, rd);
        @(negedge clk);
        addr = 32'h30; we = 1'b1; wd = 32'hCAFEF00D; Memhalf = 1'b0; Membyte = 1'b0;
        req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready0}, 32'h1);
        check("abort_mem_we", {31'h0, mem_we0}, 32'h0);
        check("abort_rdata", rdata0, 32'h0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done0) done_cnt++;
            if (k == 1) rst_n = 1'b1;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_m30", {24'h0, mem0[12'h030]}, 32'hCA);
        check("abort_m31", {24'h0, mem0[12'h031]}, 32'hFE);
        check("abort_m32", {24'h0, mem0[12'h032]}, 32'h00);
        check("abort_m33", {24'h0, mem0[12'h033]}, 32'h00);

        // SEG=0xFFC: address 4 lands on 0x1000, wrapping to 0x000
        do_access(1, 1, 32'h4, 32'hA1B2C3D4, 0, 0, 0, dc, rd);
        check("seg_done_cycle", 32'(dc), 32'd5);
        check("seg_m000", {24'h0, mem1[12'h000]}, 32'hA1);
        check("seg_m001", {24'h0, mem1[12'h001]}, 32'hB2);
        check("seg_m002", {24'h0, mem1[12'h002]}, 32'hC3);
        check("seg_m003", {24'h0, mem1[12'h003]}, 32'hD4);
        do_access(1, 0, 32'h6, 32'h0, 1, 0, 1, dc, rd);
        check("seg_half_load", rd, 32'hFFFFC3D4);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
